// File: rtl/seg7_scan_display.sv
// Multiplexed 6-digit 7-segment driver: frame-coherent input shadow, blanked digit slots, BCD decode, blink.
// Optional build macro LEADING_ZERO_BLANK_EN darkens the hour-tens digit when it is zero.
module seg7_scan_display #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_DIV    = 256,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic       sec_blank,
    input  logic       blink_hour,
    input  logic       blink_min,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    digit_q, digit_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    logic [7:0] hour_q, min_q, sec_q;
    logic       sec_blank_q, blink_hour_q, blink_min_q;

    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [5:0] dig_sel_q, dig_sel_d;

    logic       load_shadow;
    logic       lit;
    logic [3:0] nibble;
    logic       blank_lz;
    logic [5:0] dig_on;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_lz = (hour_q[7:4] == 4'd0);
`else
    assign blank_lz = 1'b0;
`endif

    assign load_shadow = (digit_q == 3'd0) && (div_q == '0);

    // Counters: slot divider, digit index, free-running blink timer.
    always_comb begin
        div_d         = div_q + DW'(1);
        digit_d       = digit_q;
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Slot 0 of every digit is dark so the previous digit's segments never ghost onto the next.
    always_comb begin
        nibble = 4'd0;
        lit    = (div_q != '0);
        case (digit_q)
            3'd0: begin
                nibble = sec_q[3:0];
                if (sec_blank_q) lit = 1'b0;
            end
            3'd1: begin
                nibble = sec_q[7:4];
                if (sec_blank_q) lit = 1'b0;
            end
            3'd2: begin
                nibble = min_q[3:0];
                if (blink_min_q && blink_phase_q) lit = 1'b0;
            end
            3'd3: begin
                nibble = min_q[7:4];
                if (blink_min_q && blink_phase_q) lit = 1'b0;
            end
            3'd4: begin
                nibble = hour_q[3:0];
                if (blink_hour_q && blink_phase_q) lit = 1'b0;
            end
            3'd5: begin
                nibble = hour_q[7:4];
                if ((blink_hour_q && blink_phase_q) || blank_lz) lit = 1'b0;
            end
            default: lit = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_dig
        assign dig_on[gi] = lit && (digit_q == 3'(gi));
    end

    always_comb begin
        seg_d     = lit ? bcd_to_seg(nibble) : 7'b0000000;
        dp_d      = lit && ((digit_q == 3'd2) || (digit_q == 3'd4));
        dig_sel_d = dig_on;
        seg_d     = seg_d ^ {7{COMMON_ANODE}};
        dp_d      = dp_d ^ COMMON_ANODE;
        dig_sel_d = dig_sel_d ^ {6{COMMON_ANODE}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            digit_q       <= 3'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            hour_q        <= 8'h00;
            min_q         <= 8'h00;
            sec_q         <= 8'h00;
            sec_blank_q   <= 1'b0;
            blink_hour_q  <= 1'b0;
            blink_min_q   <= 1'b0;
            seg_q         <= {7{COMMON_ANODE}};
            dp_q          <= COMMON_ANODE;
            dig_sel_q     <= {6{COMMON_ANODE}};
        end else begin
            div_q         <= div_d;
            digit_q       <= digit_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (load_shadow) begin
                hour_q       <= hour;
                min_q        <= min;
                sec_q        <= sec;
                sec_blank_q  <= sec_blank;
                blink_hour_q <= blink_hour;
                blink_min_q  <= blink_min;
            end
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_sel_q     <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign dig_sel = dig_sel_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: an active-high and a common-anode instance run side by side.
module tb_seg7_scan_display;
    logic       clk;
    logic       rst;
    logic [7:0] hour, min, sec;
    logic       sec_blank, blink_hour, blink_min;
    logic [6:0] seg_cc, seg_ca;
    logic       dp_cc, dp_ca;
    logic [5:0] dig_sel_cc, dig_sel_ca;

    int ecnt   = 0;
    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [5:0] dig;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t vecs [24];

    seg7_scan_display #(.SCAN_DIV(4), .BLINK_DIV(256), .COMMON_ANODE(1'b0)) u_cc (
        .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec),
        .sec_blank(sec_blank), .blink_hour(blink_hour), .blink_min(blink_min),
        .seg(seg_cc), .dp(dp_cc), .dig_sel(dig_sel_cc)
    );

    seg7_scan_display #(.SCAN_DIV(4), .BLINK_DIV(256), .COMMON_ANODE(1'b1)) u_ca (
        .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec),
        .sec_blank(sec_blank), .blink_hour(blink_hour), .blink_min(blink_min),
        .seg(seg_ca), .dp(dp_ca), .dig_sel(dig_sel_ca)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) tick();
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s edge=%0d got dig/seg/dp=%b_%b_%b expected %b_%b_%b",
                     name, ecnt, act[13:8], act[7:1], act[0], exp[13:8], exp[7:1], exp[0]);
        end else begin
            passed++;
        end
    endtask

    // Both instances compared at edge e; the common-anode one must be the bitwise inverse.
    task automatic expect_at(input string name, input int e,
                             input logic [5:0] d, input logic [6:0] s, input logic p);
        run_to(e);
        check({name, "_cc"}, {dig_sel_cc, seg_cc, dp_cc}, {d, s, p});
        check({name, "_ca"}, {dig_sel_ca, seg_ca, dp_ca}, ~{d, s, p});
        $display("edge %0d %s: dig=%b seg=%b dp=%b", ecnt, name, dig_sel_cc, seg_cc, dp_cc);
    endtask

    initial begin
        logic [6:0] dseg [6];
        logic       ddp  [6];

        // Expected digits for 23:59:07, digit 0 = seconds ones.
        dseg[0] = 7'b0000111; ddp[0] = 1'b0;
        dseg[1] = 7'b0111111; ddp[1] = 1'b0;
        dseg[2] = 7'b1101111; ddp[2] = 1'b1;
        dseg[3] = 7'b1101101; ddp[3] = 1'b0;
        dseg[4] = 7'b1001111; ddp[4] = 1'b1;
        dseg[5] = 7'b1011011; ddp[5] = 1'b0;
        for (int d = 0; d < 6; d++) begin
            for (int s = 0; s < 4; s++) begin
                if (s == 0) vecs[d*4+s] = '{6'b000000, 7'b0000000, 1'b0};
                else        vecs[d*4+s] = '{6'b000001 << d, dseg[d], ddp[d]};
            end
        end

        rst = 1'b1; hour = 8'h23; min = 8'h59; sec = 8'h07;
        sec_blank = 1'b0; blink_hour = 1'b0; blink_min = 1'b0;
        tick();
        tick();
        expect_at("reset", ecnt, 6'b000000, 7'b0000000, 1'b0);
        rst  = 1'b0;
        ecnt = 0;

        // Two full frames after release: the frame repeats every 24 edges.
        for (int e = 1; e <= 48; e++) begin
            expect_at($sformatf("frame_v%0d", (e - 1) % 24), e,
                      vecs[(e - 1) % 24].dig, vecs[(e - 1) % 24].seg, vecs[(e - 1) % 24].dp);
        end

        // Shadow: sec changes during digit 0 of the frame starting at edge 49.
        run_to(50);
        sec = 8'h48;
        expect_at("shadow_d0a", 51, 6'b000001, 7'b0000111, 1'b0);
        expect_at("shadow_d0b", 52, 6'b000001, 7'b0000111, 1'b0);
        expect_at("shadow_d1",  54, 6'b000010, 7'b0111111, 1'b0);
        expect_at("new_d0",     74, 6'b000001, 7'b1111111, 1'b0);
        expect_at("new_d1",     78, 6'b000010, 7'b1100110, 1'b0);

        // Seconds blanking for the frame starting at edge 97.
        sec_blank = 1'b1;
        for (int e = 98; e <= 104; e++) begin
            expect_at("secblank", e, 6'b000000, 7'b0000000, 1'b0);
        end
        expect_at("secblank_min", 106, 6'b000100, 7'b1101111, 1'b1);

        // Out-of-range nibble decodes to a dash (frame at 121).
        run_to(120);
        sec_blank = 1'b0;
        sec = 8'hA5;
        expect_at("a5_ones", 122, 6'b000001, 7'b1101101, 1'b0);
        expect_at("a5_dash", 126, 6'b000010, 7'b1000000, 1'b0);

        // Minute blink: phase 0 on edges 1..256, 1 on 257..512, 0 from 513.
        run_to(144);
        blink_min = 1'b1;
        expect_at("blink_p0_d2",   154, 6'b000100, 7'b1101111, 1'b1);
        expect_at("blink_p0_d2b",  250, 6'b000100, 7'b1101111, 1'b1);
        expect_at("blink_p0_d3",   254, 6'b001000, 7'b1101101, 1'b0);
        expect_at("blink_p1_d2",   274, 6'b000000, 7'b0000000, 1'b0);
        expect_at("blink_p1_d3",   278, 6'b000000, 7'b0000000, 1'b0);
        expect_at("blink_p1_hour", 282, 6'b010000, 7'b1001111, 1'b1);
        expect_at("blink_p1_late", 490, 6'b000000, 7'b0000000, 1'b0);
        expect_at("blink_p0_back", 514, 6'b000100, 7'b1101111, 1'b1);

        // Hour tens of zero (frame at 529).
        run_to(528);
        blink_min = 1'b0;
        hour = 8'h09;
        expect_at("hour_ones9", 546, 6'b010000, 7'b1101111, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        expect_at("hour_tens0", 550, 6'b000000, 7'b0000000, 1'b0);
`else
        expect_at("hour_tens0", 550, 6'b100000, 7'b0111111, 1'b0);
`endif

        // Reset asserted during digit 3, then scan restarts at digit 0.
        expect_at("pre_rst_d3", 566, 6'b001000, 7'b1101101, 1'b0);
        rst = 1'b1;
        expect_at("mid_rst",    567, 6'b000000, 7'b0000000, 1'b0);
        rst = 1'b0;
        expect_at("rel_edge1",  568, 6'b000000, 7'b0000000, 1'b0);
        expect_at("rel_d0",     569, 6'b000001, 7'b1101101, 1'b0);
        expect_at("rel_gap",    572, 6'b000000, 7'b0000000, 1'b0);
        expect_at("rel_d1",     573, 6'b000010, 7'b1000000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Consumer end of the clock's BCD display bus: takes packed-BCD hour/min/sec plus display-control flags and drives one multiplexed 6-digit 7-segment display.
- Snapshots the inputs once per frame so a digit never tears mid-frame.
- Scans digits with an inter-digit blanking cycle; decodes BCD to segments; blinks the field being set; blanks seconds when told to.

Parameters:
- SCAN_DIV, 4, clk cycles per digit slot; minimum 2; slot cycle 0 is blanking.
- BLINK_DIV, 256, clk cycles per blink half-period.
- COMMON_ANODE, 0, 0 = seg/dig_sel active-high; 1 = both inverted. "Off" below means the inactive level.

Ports:
- clk  in  1  scan clock (1024 Hz on board)
- rst  in  1  synchronous, active-high reset
- hour  in  8  packed BCD, hour[7:4] tens
- min  in  8  packed BCD
- sec  in  8  packed BCD
- sec_blank  in  1  1 = seconds digits dark (alarm/set modes)
- blink_hour  in  1  1 = hour digits blink
- blink_min  in  1  1 = minute digits blink
- seg  out  7  seg[0]=a … seg[6]=g
- dp  out  1  decimal point
- dig_sel  out  6  one-hot digit enable

Behaviour:
- State: digit_idx 0..5, div_cnt 0..SCAN_DIV-1, blink_cnt, blink_phase, input shadow registers.
- Every register uses sync rst. Reset values: digit_idx=0, div_cnt=0, blink_cnt=0, blink_phase=0, shadow=0; seg, dp, dig_sel all off.
- Counter update each edge: div_cnt wraps at SCAN_DIV-1. On that wrap, digit_idx increments, 5 wraps to 0. Frame = 6*SCAN_DIV cycles.
- Shadow load: on any edge where the pre-edge state is digit_idx=0, div_cnt=0 and rst=0, capture hour, min, sec, sec_blank, blink_hour, blink_min. The shadow holds for the rest of the frame.
- Digit map: 0=sec ones, 1=sec tens, 2=min ones, 3=min tens, 4=hour ones, 5=hour tens.
- All outputs are registered and reflect the pre-edge (digit_idx, div_cnt), so there is one cycle of latency.
  - Pre-edge div_cnt=0: all outputs off (anti-ghost blanking).
  - Otherwise: dig_sel bit digit_idx on; seg = decode of the shadow nibble; dp on for digits 2 and 4 only.
- Decode (seg[6:0]):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - nibble >9 = 1000000 (dash).
- Blanked digit (seg, dp, dig_sel all off):
  - digits 0–1 when shadow sec_blank=1;
  - digits 4–5 when shadow blink_hour=1 and blink_phase=1;
  - digits 2–3 when shadow blink_min=1 and blink_phase=1.
- Blink counter: free-running. blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles at the wrap. Unaffected by the blink inputs.
- Reset asserted mid-frame: the next edge gives outputs off and counters back to (0,0). A new shadow is captured on the first edge after rst deasserts.
- At most one dig_sel bit is active at any time; in the blanking cycle none are active.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: digit 5 is blanked whenever shadow hour[7:4]==0 (" 9:05:00").
  - Undefined: digit 5 shows 0 normally.
  - The dash rule still applies to nibbles >9 in both cases.

Test Plan:
- Reset decode: rst 1 cycle, then hour=23, min=59, sec=07, SCAN_DIV=4, COMMON_ANODE=0 -> edge1 after release: outputs off; edges 2–4: dig_sel=000001, seg=0000111, dp=0; edge 5: all off; edges 6–8: dig_sel=000010, seg=0111111.
- Full frame: same inputs -> digits 2..5 show seg 1101111, 1101101, 1001111, 1011011; dp=1 only on digits 2 and 4; frame repeats every 24 cycles.
- Shadow: change sec to 8'h48 at cycle 10 of a frame -> digits 0–1 keep 7/0 for that frame; the next frame shows 8/4.
- Blanking: sec_blank=1 -> dig_sel never 000001/000010. sec=8'hA5 with sec_blank=0 -> digit 1 seg=1000000.
- Blink: blink_min=1, BLINK_DIV=256 -> digits 2–3 lit in frames starting with blink_phase=0, dark while phase=1 (toggle every 256 cycles); hour digits unaffected.
- Polarity/reset: COMMON_ANODE=1 -> digit 0 of 7 gives seg=1111000, dig_sel=111110, blanking cycle dig_sel=111111. Assert rst mid-digit-3 -> next edge all outputs off; scan restarts at digit 0.
